// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: byte-issue bus between the arbiter and one uart_tx.
// master = arbiter side (drives dv/data), slave = uart_tx side.
interface uart_tx_arbiter_if #(
    parameter int p_WORD_LEN = 8
);
    logic                  tx_dv;
    logic [p_WORD_LEN-1:0] tx_data;
    logic                  tx_active;
    logic                  tx_done;

    modport master (output tx_dv, output tx_data, input tx_active, input tx_done);
    modport slave  (input tx_dv, input tx_data, output tx_active, output tx_done);
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx among p_NUM_REQ requesters.
// One byte is issued per grant as a single-cycle dv pulse; the arbiter then
// waits for the frame to start (with timeout) and finish before re-arbitrating.
// Optional feature macro: UART_ARB_LOCK_EN (burst lock keeps the transmitter
// with a requester that holds i_lock across frame completion).
module uart_tx_arbiter #(
    parameter int p_NUM_REQ     = 4,
    parameter int p_WORD_LEN    = 8,
    parameter int p_ACT_TIMEOUT = 4
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic [p_NUM_REQ-1:0]            i_req,
    input  logic [p_NUM_REQ*p_WORD_LEN-1:0] i_data,
    input  logic [p_NUM_REQ-1:0]            i_lock,
    output logic [p_NUM_REQ-1:0]            o_ack,
    output logic [p_NUM_REQ-1:0]            o_grant,
    uart_tx_arbiter_if.master               tx_bus,
    output logic                            o_done,
    output logic                            o_err,
    output logic                            o_busy
);
    localparam int PTR_W = $clog2(p_NUM_REQ);
    localparam int CNT_W = $clog2(p_ACT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(p_ACT_TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_ACT, S_WAIT_DONE} state_e;

    state_e                state_q, state_d;
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [p_NUM_REQ-1:0]  grant_q, grant_d;
    logic [p_WORD_LEN-1:0] data_q, data_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic [p_NUM_REQ-1:0]  cand;
    logic                  cand_locked;
    logic                  win_vld;
    logic [PTR_W-1:0]      win_idx;
    logic                  take;

`ifdef UART_ARB_LOCK_EN
    logic [p_NUM_REQ-1:0]  lock_q, lock_d;

    // Locked requesters that are still asking form the candidate set on their own.
    always_comb begin
        cand        = i_req;
        cand_locked = 1'b0;
        if (|(lock_q & i_req)) begin
            cand        = lock_q & i_req;
            cand_locked = 1'b1;
        end
    end

    // Capture lock&req as the frame completes; the next grant consumes it.
    always_comb begin
        lock_d = lock_q;
        if (take)
            lock_d = '0;
        else if (state_q == S_WAIT_DONE && tx_bus.tx_done)
            lock_d = i_lock & i_req;
    end

    // Lock snapshot register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) lock_q <= '0;
        else          lock_q <= lock_d;
    end
`else
    logic unused_lock;
    assign unused_lock = ^i_lock;
    assign cand        = i_req;
    assign cand_locked = 1'b0;
`endif

    // Round-robin search over the candidates starting at rr_ptr, wrapping.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = 0; i < p_NUM_REQ; i++) begin
            if (!win_vld && cand[(int'(rr_ptr_q) + i) % p_NUM_REQ]) begin
                win_vld = 1'b1;
                win_idx = PTR_W'((int'(rr_ptr_q) + i) % p_NUM_REQ);
            end
        end
    end

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    // FSM next state, timeout counter and completion/error pulses.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        take    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Never launch while the transmitter still reports a frame.
                if (win_vld && !tx_bus.tx_active) begin
                    take    = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_ACT;
                cnt_d   = '0;
            end
            S_WAIT_ACT: begin
                cnt_d = cnt_inc;
                // A done without ever seeing active still counts as completion.
                if (tx_bus.tx_done) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (tx_bus.tx_active) begin
                    state_d = S_WAIT_DONE;
                end else if (cnt_inc == CNT_MAX) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (tx_bus.tx_done) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Grant, byte and pointer updates on the IDLE->ISSUE edge; grant clears on return to IDLE.
    always_comb begin
        grant_d  = grant_q;
        data_d   = data_q;
        rr_ptr_d = rr_ptr_q;
        if (take) begin
            grant_d          = '0;
            grant_d[win_idx] = 1'b1;
            data_d           = i_data[int'(win_idx)*p_WORD_LEN +: p_WORD_LEN];
            if (!cand_locked)
                rr_ptr_d = (win_idx == PTR_W'(p_NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end else if (state_d == S_IDLE) begin
            grant_d = '0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign tx_bus.tx_dv   = (state_q == S_ISSUE);
    assign tx_bus.tx_data = data_q;
    assign o_ack          = (state_q == S_ISSUE) ? grant_q : '0;
    assign o_grant        = grant_q;
    assign o_done         = done_q;
    assign o_err          = err_q;
    assign o_busy         = (state_q != S_IDLE);
endmodule
